// File: rtl/fifo_playback_pkg.sv
// Shared types and helpers for the FIFO playback reader: FSM states, gain format
// constants and the saturating clamp used by the gain stage.
package fifo_playback_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        READ,
        LATENCY,
        CAPTURE,
        UNDERRUN
    } state_e;

    localparam int              GAIN_W     = 8;
    localparam int              GAIN_FRAC  = 7;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'd128;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            sat_clamp = hi;
        end else if (v < lo) begin
            sat_clamp = lo;
        end else begin
            sat_clamp = v;
        end
    endfunction

endpackage

// File: rtl/sample_gain_sat.sv
// Combinational Q1.7 gain stage: signed sample times unsigned gain, arithmetic
// shift back to sample scale, then saturate to the sample width.
module sample_gain_sat
    import fifo_playback_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0]  din,
    input  logic        [GAIN_W-1:0] gain,
    output logic signed [WIDTH-1:0]  dout
);

    localparam int PW = WIDTH + GAIN_W + 1;

    logic signed [GAIN_W:0] gain_s;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shifted;

    always_comb begin
        gain_s  = {1'b0, gain};
        prod    = PW'(din) * PW'(gain_s);
        // Arithmetic shift truncates toward -inf, matching the reference model.
        shifted = prod >>> GAIN_FRAC;
        dout    = WIDTH'(sat_clamp(64'(shifted), WIDTH));
    end

endmodule

// File: rtl/fifo_playback_reader.sv
// Paces FIFO reads at the sample rate, tracks FIFO occupancy from the writer's strobe,
// and emits gained samples. Define UNDERRUN_HOLD_EN to repeat the last sample on underrun.
module fifo_playback_reader
    import fifo_playback_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 512,
    parameter int SAMPLE_PERIOD = 2083,
    parameter int RD_LATENCY    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         wr_mon,
    output logic                         fifo_rd,
    input  logic        [WIDTH-1:0]      fifo_dout,
    input  logic        [GAIN_W-1:0]     gain,
    output logic signed [WIDTH-1:0]      sample_out,
    output logic                         sample_valid,
    output logic                         underrun,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          tick_cnt_q, tick_cnt_d;
    logic [LAT_W-1:0]          lat_cnt_q, lat_cnt_d;
    logic [LVL_W-1:0]          level_q, level_d;
    logic signed [WIDTH-1:0]   sample_out_q, sample_out_d;
    logic                      sample_valid_q, sample_valid_d;
    logic                      underrun_q, underrun_d;
    logic                      wr_mon_q;

    logic                      wr_rise;
    logic                      tick;
    logic                      rd_cycle;
    logic                      lvl_inc;
    logic signed [WIDTH-1:0]   gained;

    sample_gain_sat #(
        .WIDTH (WIDTH)
    ) u_gain (
        .din  (fifo_dout),
        .gain (gain),
        .dout (gained)
    );

    always_comb begin
        wr_rise    = wr_mon & ~wr_mon_q;
        tick       = enable && (tick_cnt_q == CNT_LAST);
        tick_cnt_d = (!enable || tick) ? '0 : tick_cnt_q + CNT_W'(1);
        rd_cycle   = (state_q == READ);
    end

    always_comb begin
        state_d        = state_q;
        lat_cnt_d      = lat_cnt_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
        underrun_d     = underrun_q;

        case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    state_d = (level_q != '0) ? READ : UNDERRUN;
                end
            end
            READ: begin
                lat_cnt_d = '0;
                state_d   = (RD_LATENCY > 1) ? LATENCY : CAPTURE;
            end
            LATENCY: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            CAPTURE: begin
                sample_out_d   = gained;
                sample_valid_d = 1'b1;
                state_d        = enable ? WAIT_TICK : IDLE;
            end
            UNDERRUN: begin
                underrun_d     = 1'b1;
`ifdef UNDERRUN_HOLD_EN
                sample_out_d   = sample_out_q;
`else
                sample_out_d   = '0;
`endif
                sample_valid_d = 1'b1;
                state_d        = enable ? WAIT_TICK : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Disabling playback clears the sticky flag once the in-flight sample is done.
        if (!enable && state_q != UNDERRUN) underrun_d = 1'b0;
    end

    // Simultaneous write and read cancel even when the level sits at DEPTH.
    always_comb begin
        lvl_inc = wr_rise && ((level_q != LVL_FULL) || rd_cycle);
        level_d = level_q;
        if (lvl_inc && !rd_cycle) begin
            level_d = level_q + LVL_W'(1);
        end else if (!lvl_inc && rd_cycle) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            tick_cnt_q     <= '0;
            lat_cnt_q      <= '0;
            level_q        <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
            wr_mon_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            lat_cnt_q      <= lat_cnt_d;
            level_q        <= level_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            underrun_q     <= underrun_d;
            wr_mon_q       <= wr_mon;
        end
    end

    assign fifo_rd      = rd_cycle;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign underrun     = underrun_q;
    assign level        = level_q;

endmodule
